sram_req_sched: RTL and testbench

Two-port request scheduler placed directly upstream of the SRAM connector. It accepts byte-wide read/write requests from two clients over valid/ready handshakes, arbitrates round-robin, and drives the connector's single-cycle `write`/`read` strobes. It captures the connector's registered `data_out` and returns read data to the issuing client with a one-cycle response pulse.

---
 rtl/sram_req_sched_pkg.sv | 26 ++
 rtl/sram_req_sched_rr_arb2.sv | 23 ++
 rtl/sram_req_sched.sv | 170 +++++++++++++++++
 tb/tb_sram_req_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_sched_pkg
// Description : Shared constants for the two-client SRAM request scheduler:
//               FSM state encodings, byte-lane enable value and a small
//               helper that turns a one-hot grant into a client ID.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_req_sched_pkg;

    // Scheduler FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_CAP  = 2'd3;

    // Only the low byte lane of the connector is ever used
    localparam logic [1:0] BYTE_LO = 2'b01;

    // One-hot two-way grant to client index (bit 1 set means client 1)
    function automatic logic gnt_to_id(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_req_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter, purely combinational.
//               On a tie the client that was not granted last wins.
//               The last-grant history is held by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie, 'last' selects who waits
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] |  last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule
`default_nettype wire

// File: rtl/sram_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_sched
// Description : Two-client byte-wide request scheduler in front of the SRAM
//               connector. Round-robin arbitration, single-cycle registered
//               write/read strobes, registered read-data capture and a
//               one-cycle response pulse back to the issuing client.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_req_sched
    import sram_req_sched_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [1:0]        mem_byte_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q,       state_d;
    logic              last_grant_q,  last_grant_d;
    logic              cmd_id_q,      cmd_id_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic              mem_write_q,   mem_write_d;
    logic              mem_read_q,    mem_read_d;
    logic [1:0]        mem_byte_en_q, mem_byte_en_d;
    logic [1:0]        rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;

    // ------------------------------------------------------------------
    // Arbitration and accept decode
    // ------------------------------------------------------------------
    logic [1:0]        gnt;
    logic              accept;
    logic              acc_id;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_grant_q),
        .gnt  (gnt)
    );

    // Ready is the grant, but only while the scheduler can take a command
    always_comb begin
        req_ready = (state_q == ST_IDLE) ? gnt : 2'b00;
    end

    // Select the winning client's command fields
    always_comb begin
        accept    = |req_ready;
        acc_id    = gnt_to_id(req_ready);
        acc_we    = acc_id ? req_we[1]  : req_we[0];
        acc_addr  = acc_id ? req_addr1  : req_addr0;
        acc_wdata = acc_id ? req_wdata1 : req_wdata0;
    end

    // ------------------------------------------------------------------
    // Next-state logic. Strobes and byte enables default low so they are
    // only ever high for the single cycle following an accept.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cmd_id_d      = cmd_id_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        mem_byte_en_d = 2'b00;
        rsp_valid_d   = 2'b00;
        rsp_rdata_d   = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_id_d      = acc_id;
                    last_grant_d  = acc_id;
                    mem_addr_d    = acc_addr;
                    mem_wdata_d   = acc_wdata;
                    mem_byte_en_d = BYTE_LO;
                    if (acc_we) begin
                        mem_write_d = 1'b1;
                        state_d     = ST_WR;
                    end else begin
                        mem_read_d  = 1'b1;
                        state_d     = ST_RD;
                    end
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD: begin
                // Connector samples the read at the end of this cycle
                state_d = ST_CAP;
            end
            ST_CAP: begin
                // Connector's registered data_out is valid in this cycle
                rsp_rdata_d           = mem_rdata;
                rsp_valid_d[cmd_id_q] = 1'b1;
                state_d               = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all state; reset drops any in-flight command immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            cmd_id_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_byte_en_q <= 2'b00;
            rsp_valid_q   <= 2'b00;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cmd_id_q      <= cmd_id_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            mem_byte_en_q <= mem_byte_en_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    // Drive outputs straight from registers
    always_comb begin
        mem_write   = mem_write_q;
        mem_read    = mem_read_q;
        mem_byte_en = mem_byte_en_q;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        rsp_valid   = rsp_valid_q;
        rsp_rdata   = rsp_rdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_req_sched
// Description : Directed self-checking bench for sram_req_sched with a
//               registered-output SRAM connector model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_sched;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [1:0]        req_we = 2'b00;
    logic [ADDR_W-1:0] req_addr0 = '0;
    logic [ADDR_W-1:0] req_addr1 = '0;
    logic [DATA_W-1:0] req_wdata0 = '0;
    logic [DATA_W-1:0] req_wdata1 = '0;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_write;
    logic              mem_read;
    logic [1:0]        mem_byte_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int bad_both = 0;
    int bad_rdy = 0;
    logic [DATA_W-1:0] rq0[$];

    sram_req_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .req_wdata0  (req_wdata0),
        .req_wdata1  (req_wdata1),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_byte_en (mem_byte_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM connector model: registered data_out, low byte lane only
    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sram_dout = '0;
    assign mem_rdata = sram_dout;
    always @(posedge clk) begin
        if (mem_write) sram[mem_addr] <= mem_wdata;
        if (mem_read)  sram_dout <= sram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Continuous observers sampled mid-cycle
    always @(negedge clk) begin
        if (rsp_valid != 2'b00) rsp_cnt <= rsp_cnt + 1;
        if (rsp_valid[0]) rq0.push_back(rsp_rdata);
        if (mem_write && mem_read) bad_both <= bad_both + 1;
        if (req_ready == 2'b11) bad_rdy <= bad_rdy + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int c);
        for (int n = 0; n < 10 && req_ready[c] == 1'b0; n++) step();
        chk("ready_wait", {31'd0, req_ready[c]}, 32'd1);
    endtask

    initial begin
        int prev;
        int snap;

        // ---------------- Reset state ----------------
        step(); step();
        chk("rst_ready",   req_ready,   2'b00);
        chk("rst_rspv",    rsp_valid,   2'b00);
        chk("rst_rdata",   rsp_rdata,   8'h00);
        chk("rst_write",   mem_write,   1'b0);
        chk("rst_read",    mem_read,    1'b0);
        chk("rst_be",      mem_byte_en, 2'b00);
        chk("rst_addr",    mem_addr,    12'h000);
        chk("rst_wdata",   mem_wdata,   8'h00);
        rst = 1'b1;
        step();

        // ---------------- Single write, client 0 ----------------
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr0 = 12'h0A5; req_wdata0 = 8'h3C;
        #1;
        chk("wr_ready", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        chk("wr_strobe", mem_write,   1'b1);
        chk("wr_addr",   mem_addr,    12'h0A5);
        chk("wr_data",   mem_wdata,   8'h3C);
        chk("wr_be",     mem_byte_en, 2'b01);
        chk("wr_noread", mem_read,    1'b0);
        chk("wr_busy",   req_ready,   2'b00);
        step();
        chk("wr_strobe_off", mem_write,   1'b0);
        chk("wr_be_off",     mem_byte_en, 2'b00);
        chk("wr_addr_hold",  mem_addr,    12'h0A5);
        step(); step(); step();
        chk("wr_no_rsp", rsp_cnt, 0);

        // ---------------- Write then read back, client 1 ----------------
        req_valid[1] = 1'b1; req_we[1] = 1'b1;
        req_addr1 = 12'h010; req_wdata1 = 8'h7E;
        #1;
        chk("wr1_ready", req_ready, 2'b10);
        step();                         // write accepted
        req_we[1] = 1'b0;               // present the read next
        step();
        chk("rd1_ready", req_ready, 2'b10);
        step();                         // read accepted
        req_valid[1] = 1'b0;
        chk("rd1_strobe", mem_read,    1'b1);
        chk("rd1_be",     mem_byte_en, 2'b01);
        chk("rd1_addr",   mem_addr,    12'h010);
        step();
        chk("rd1_cap_norsp", rsp_valid, 2'b00);
        chk("rd1_cap_noread", mem_read, 1'b0);
        step();
        chk("rd1_rspv",  rsp_valid, 2'b10);
        chk("rd1_rdata", rsp_rdata, 8'h7E);
        step();
        chk("rd1_rsp_pulse", rsp_valid, 2'b00);
        chk("rd1_rdata_hold", rsp_rdata, 8'h7E);

        // ---------------- Contention: both hold reads ----------------
        req_we = 2'b00;
        req_addr0 = 12'h0A5; req_addr1 = 12'h010;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("ct_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            step(); step(); step();
            chk("ct_rspv",  rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("ct_rdata", rsp_rdata, (k % 2 == 0) ? 8'h3C : 8'h7E);
        end
        req_valid = 2'b00;
        step(); step();

        // ---------------- Back-to-back: 4 writes then 4 reads ----------------
        rq0.delete();
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            req_addr0 = 12'h100 + 12'(i); req_wdata0 = 8'hA0 + 8'(i);
            req_we[0] = 1'b1; req_valid[0] = 1'b1;
            wait_ready(0);
            if (i > 0) chk("b2b_wr_space", cyc - prev, 2);
            prev = cyc;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            req_addr0 = 12'h100 + 12'(i);
            req_we[0] = 1'b0; req_valid[0] = 1'b1;
            wait_ready(0);
            if (i > 0) chk("b2b_rd_space", cyc - prev, 3);
            prev = cyc;
            step();
        end
        req_valid[0] = 1'b0;
        step(); step(); step();
        chk("b2b_rsp_count", rq0.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_rdata", (i < rq0.size()) ? {24'd0, rq0[i]} : 32'hDEAD, 8'hA0 + 8'(i));
        end

        // ---------------- Reset during RD ----------------
        req_addr0 = 12'h101; req_we[0] = 1'b0; req_valid[0] = 1'b1;
        wait_ready(0);
        step();
        chk("mr_read_on", mem_read, 1'b1);
        snap = rsp_cnt;
        rst = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("mr_read",  mem_read,    1'b0);
        chk("mr_write", mem_write,   1'b0);
        chk("mr_be",    mem_byte_en, 2'b00);
        chk("mr_addr",  mem_addr,    12'h000);
        chk("mr_wdata", mem_wdata,   8'h00);
        chk("mr_rdata", rsp_rdata,   8'h00);
        chk("mr_rspv",  rsp_valid,   2'b00);
        chk("mr_ready", req_ready,   2'b00);
        step(); step();
        rst = 1'b1;
        step(); step(); step(); step();
        chk("mr_no_rsp", rsp_cnt, snap);
        req_we = 2'b11;
        req_addr0 = 12'h200; req_addr1 = 12'h201;
        req_valid = 2'b11;
        #1;
        chk("mr_first_tie", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        chk("mr_tie_addr", mem_addr, 12'h200);
        step(); step();

        // ---------------- Global invariants ----------------
        chk("never_rd_wr", bad_both, 0);
        chk("never_rdy11", bad_rdy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
